// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_arbiter #(
  parameter int DW = 32,
  parameter int RW = 64,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req0_sel,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [2:0]    req1_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  input  logic [RW-1:0] alu_out,
  input  logic          alu_zero,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [RW-1:0] rsp_data,
  output logic          rsp_zero,
  output logic          rsp_illegal,
  output logic          busy,
  output logic [CW-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic prio, op_id, gnt, gnt_id;
  logic [DW-1:0] op_a, op_b;
  logic [2:0] op_sel;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // grant selection, next state and handshake outputs
  always_comb begin
    gnt = (state == IDLE) && (req0_valid || req1_valid);
    gnt_id = (req0_valid && req1_valid) ? prio : req1_valid;
    req0_ready = gnt && !gnt_id;
    req1_ready = gnt && gnt_id;
    rsp_valid = state == RESP;
    busy = state != IDLE;
    state_n = (state == IDLE) ? (gnt ? EXEC : IDLE) :
              (state == EXEC) ? RESP :
              (state == RESP && !rsp_ready) ? RESP : IDLE;
  end
  // latch winning request, capture ALU result, count completed handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
      op_id <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      op_sel <= '0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_illegal <= 1'b0;
      ops_done <= '0;
    end else begin
      if (gnt) begin
        op_id <= gnt_id;
        op_a <= gnt_id ? req1_a : req0_a;
        op_b <= gnt_id ? req1_b : req0_b;
        op_sel <= gnt_id ? req1_sel : req0_sel;
        prio <= !gnt_id;
      end
      if (state == EXEC) begin
        rsp_data <= alu_out;
        rsp_zero <= alu_zero;
        rsp_illegal <= op_sel < 3'd3;
        rsp_id <= op_id;
      end
      if (state == RESP && rsp_ready)
        ops_done <= ops_done + CW'(1);
    end
  end
  assign alu_a = op_a;
  assign alu_b = op_b;
  assign alu_sel = op_sel;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, alu_a, alu_b;
  logic [2:0] req0_sel = 0, req1_sel = 0, alu_sel;
  logic [63:0] alu_out, rsp_data;
  logic alu_zero, rsp_valid, rsp_ready = 0, rsp_id, rsp_zero, rsp_illegal, busy;
  logic [3:0] ops_done;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_arbiter #(.DW(32), .RW(64), .CW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .busy(busy), .ops_done(ops_done)
  );
  function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
    case (s)
      3'd3: return {32'b0, a} + {32'b0, b};
      3'd4: return {32'b0, a} - {32'b0, b};
      3'd5: return {32'b0, a | b};
      3'd6: return {32'b0, a & b};
      3'd7: return {32'b0, a} << b;
      default: return 64'd0;
    endcase
  endfunction
  assign alu_out = ref_alu(alu_a, alu_b, alu_sel);
  assign alu_zero = alu_out == 64'd0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // model: one outstanding operation, its age in cycles since acceptance, and whose turn it is on a tie
  bit m_busy = 0, m_turn = 0, l_id = 0, m_id = 0, m_zero = 0, m_ill = 0;
  int m_age = 0, m_ops = 0;
  logic [31:0] l_a = 0, l_b = 0;
  logic [2:0] l_sel = 0;
  logic [63:0] m_data = 0;
  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] s0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] s1,
                      input logic rr, input logic r);
    bit e0, e1;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
    rsp_ready = rr; rst = r;
    e0 = !m_busy && v0 && (!v1 || !m_turn);
    e1 = !m_busy && v1 && (!v0 || m_turn);
    @(negedge clk);
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("rsp_valid", rsp_valid, m_busy && m_age == 2);
    check("busy", busy, m_busy);
    check("ops_done", ops_done, 64'(m_ops));
    check("alu_a", alu_a, l_a);
    check("alu_b", alu_b, l_b);
    check("alu_sel", alu_sel, l_sel);
    check("rsp_id", rsp_id, m_id);
    check("rsp_data", rsp_data, m_data);
    check("rsp_zero", rsp_zero, m_zero);
    check("rsp_illegal", rsp_illegal, m_ill);
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_turn = 0; l_id = 0; m_id = 0; m_zero = 0; m_ill = 0;
      m_age = 0; m_ops = 0; l_a = 0; l_b = 0; l_sel = 0; m_data = 0;
    end else if (m_busy && m_age == 2) begin
      if (rr) begin
        m_busy = 0;
        m_ops = (m_ops + 1) % 16;
      end
    end else if (m_busy) begin
      m_age = 2;
      m_id = l_id;
      m_data = ref_alu(l_a, l_b, l_sel);
      m_zero = m_data == 64'd0;
      m_ill = l_sel < 3'd3;
    end else if (e0 || e1) begin
      l_id = e1;
      l_a = e1 ? a1 : a0;
      l_b = e1 ? b1 : b0;
      l_sel = e1 ? s1 : s0;
      m_turn = !e1;
      m_busy = 1;
      m_age = 1;
    end
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 5, 7, 3, 0, 0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (12) step(1, 9, 9, 4, 1, 1, 4, 7, 1, 0);
    repeat (4) step(0, 0, 0, 0, 1, 3, 3, 1, 1, 0);
    step(1, 2, 3, 3, 1, 4, 5, 5, 0, 0);
    repeat (7) step(1, 2, 3, 3, 1, 4, 5, 5, 0, 0);
    repeat (6) step(1, 2, 3, 3, 1, 4, 5, 5, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 8, 1, 6, 1, 8, 2, 3, 1, 0);
    step(1, 8, 1, 6, 1, 8, 2, 3, 1, 1);
    repeat (4) step(1, 8, 1, 6, 1, 8, 2, 3, 1, 0);
    repeat (60) step(1, 1, 1, 3, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a0, b0, a1, b1;
      a0 = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 15);
      b0 = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 15);
      a1 = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 15);
      b1 = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 15);
      step($urandom_range(0, 9) < 7, a0, b0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 7, a1, b1, 3'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
